// File: rtl/mips32r2_tlb_ctrl_pkg.sv
// Shared MIPS32r2 TLB types: entry image, CP0 TLB op codes and index-width helper.
package mips32r2_tlb_ctrl_pkg;

    localparam int unsigned TLB_NUM_ENTRIES = 64;

    typedef struct packed {
        logic [15:0] mask;
        logic [18:0] vpn2;
        logic        g;
        logic [7:0]  asid;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        TLBP  = 2'd0,
        TLBR  = 2'd1,
        TLBWI = 2'd2,
        TLBWR = 2'd3
    } tlb_op_t;

    function automatic int unsigned tlb_iw(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mips32r2_tlb_ctrl_random.sv
// CP0 Random register: counts down from NUM_ENTRIES-1 to Wired, then wraps.
module mips32r2_tlb_random
    import mips32r2_tlb_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_ENTRIES = TLB_NUM_ENTRIES,
    localparam int unsigned IW          = tlb_iw(NUM_ENTRIES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [IW-1:0] cp0_wired,
    input  logic          wired_write,
    output logic [IW-1:0] random
);

    localparam logic [IW-1:0] TOP = IW'(NUM_ENTRIES - 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            random <= TOP;
        end else if (wired_write || (cp0_wired >= TOP) || (random <= cp0_wired)) begin
            random <= TOP;
        end else begin
            random <= random - 1'b1;
        end
    end

endmodule

// File: rtl/mips32r2_tlb_ctrl.sv
// TLB instruction sequencer: maps TLBP/TLBR/TLBWI/TLBWR onto the TLB probe/read/write ports.
module mips32r2_tlb_ctrl
    import mips32r2_tlb_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_ENTRIES = TLB_NUM_ENTRIES,
    localparam int unsigned IW          = tlb_iw(NUM_ENTRIES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    input  logic [1:0]    cmd_op,
    output logic          cmd_ready,
    input  logic [IW-1:0] cp0_index,
    input  logic [IW-1:0] cp0_wired,
    input  logic          wired_write,
    input  logic [18:0]   cp0_vpn2,
    input  logic [7:0]    cp0_asid,
    input  tlb_entry_t    cp0_entry,
    output logic [IW-1:0] random,
    output logic          done,
    output logic [1:0]    done_op,
    output logic [IW-1:0] res_index,
    output logic          res_probe_fail,
    output tlb_entry_t    res_entry,
    output logic [IW-1:0] tlb_r_index,
    input  logic          tlb_r_ready,
    input  tlb_entry_t    tlb_r_resp,
    output logic          tlb_w_valid,
    output logic [IW-1:0] tlb_w_index,
    output tlb_entry_t    tlb_w_data,
    input  logic          tlb_w_ready,
    output logic          tlb_p_valid,
    output logic [18:0]   tlb_p_ivpn2,
    output logic [7:0]    tlb_p_iasid,
    input  logic          tlb_p_ready,
    input  logic [IW-1:0] tlb_p_index,
    input  logic          tlb_p_miss
);

    typedef enum logic [1:0] {IDLE, PROBE, READ, WRITE} state_t;

    state_t  state, next_state;
    tlb_op_t op_q;
    logic    accept, complete;

    mips32r2_tlb_random #(.NUM_ENTRIES(NUM_ENTRIES)) u_random (
        .clock       (clock),
        .reset       (reset),
        .cp0_wired   (cp0_wired),
        .wired_write (wired_write),
        .random      (random)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        cmd_ready   = 1'b0;
        tlb_p_valid = 1'b0;
        tlb_w_valid = 1'b0;
        accept      = 1'b0;
        complete    = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    unique case (tlb_op_t'(cmd_op))
                        TLBP:    next_state = PROBE;
                        TLBR:    next_state = READ;
                        default: next_state = WRITE;
                    endcase
                end
            end
            PROBE: begin
                tlb_p_valid = 1'b1;
                complete    = tlb_p_ready;
            end
            READ:    complete = tlb_r_ready;
            WRITE: begin
                tlb_w_valid = 1'b1;
                complete    = tlb_w_ready;
            end
            default: next_state = IDLE;
        endcase
        if (complete) next_state = IDLE;
    end

    // Request fields are captured only at acceptance so they stay stable while the TLB stalls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q           <= TLBP;
            tlb_r_index    <= '0;
            tlb_w_index    <= '0;
            tlb_w_data     <= '0;
            tlb_p_ivpn2    <= '0;
            tlb_p_iasid    <= '0;
            done           <= 1'b0;
            done_op        <= '0;
            res_index      <= '0;
            res_probe_fail <= 1'b0;
            res_entry      <= '0;
        end else begin
            done <= complete;
            if (accept) begin
                op_q        <= tlb_op_t'(cmd_op);
                tlb_r_index <= cp0_index;
                tlb_w_index <= (tlb_op_t'(cmd_op) == TLBWR) ? random : cp0_index;
                tlb_w_data  <= cp0_entry;
                tlb_p_ivpn2 <= cp0_vpn2;
                tlb_p_iasid <= cp0_asid;
            end
            if (complete) begin
                done_op <= op_q;
                if (state == PROBE) begin
                    res_probe_fail <= tlb_p_miss;
                    res_index      <= tlb_p_miss ? '0 : tlb_p_index;
                end
                if (state == READ) res_entry <= tlb_r_resp;
            end
        end
    end

endmodule
